// File: rtl/priority_drain_sequencer.sv
// Captures one W-bit request word and drains its set bits as an index stream, highest bit first.
// Optional macro PRIORITY_DRAIN_EMPTY_BEAT_EN adds a single marker beat for an all-zero word.
module priority_drain_sequencer #(
    parameter  int W  = 8,
    localparam int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_req,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic [IW:0]   out_seq,
    output logic          out_none
);

`ifdef PRIORITY_DRAIN_EMPTY_BEAT_EN
    typedef enum logic [1:0] {IDLE, SERVE, EMPTY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SERVE} state_t;
`endif

    state_t        state_q, state_d;
    logic [W-1:0]  pend_q, pend_d;
    logic [IW:0]   seq_q, seq_d;
    logic [IW-1:0] top_idx;
    logic          top_only;

    // Later iterations win, so the highest set bit ends up in top_idx.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (pend_q[i]) top_idx = IW'(i);
        end
    end

    assign top_only = (pend_q != '0) && ((pend_q & (pend_q - W'(1))) == '0);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        pend_d  = pend_q;
        seq_d   = seq_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pend_d = in_req;
                    seq_d  = '0;
                    if (in_req != '0) state_d = SERVE;
`ifdef PRIORITY_DRAIN_EMPTY_BEAT_EN
                    else state_d = EMPTY;
`endif
                end
            end
            SERVE: begin
                if (out_ready) begin
                    pend_d[top_idx] = 1'b0;
                    seq_d           = seq_q + (IW+1)'(1);
                    if (top_only) state_d = IDLE;
                end
            end
`ifdef PRIORITY_DRAIN_EMPTY_BEAT_EN
            EMPTY: begin
                if (out_ready) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            seq_q   <= seq_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q != IDLE);
    assign out_idx   = (state_q == SERVE) ? top_idx : '0;
    assign out_seq   = (state_q == SERVE) ? seq_q : '0;

`ifdef PRIORITY_DRAIN_EMPTY_BEAT_EN
    assign out_none  = (state_q == EMPTY);
`else
    assign out_none  = 1'b0;
`endif

    assign out_last  = (state_q == SERVE) ? top_only : out_none;

endmodule
